// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: requester and RAM-side signals of the RAM port arbiter.
// slave = arbiter view, master = requesters plus RAM view.
interface ram_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0] p0Address;
  logic [DW-1:0] p0WriteData;
  logic          p0ReadReq;
  logic          p0WriteReq;
  logic [DW-1:0] p0ReadData;
  logic          p0ReadAck;
  logic          p0WriteAck;
  logic [AW-1:0] p1Address;
  logic [DW-1:0] p1WriteData;
  logic          p1ReadReq;
  logic          p1WriteReq;
  logic [DW-1:0] p1ReadData;
  logic          p1ReadAck;
  logic          p1WriteAck;
  logic [AW-1:0] ramAddress;
  logic [DW-1:0] ramOut;
  logic          readReq;
  logic          writeReq;
  logic [DW-1:0] ramIn;
  logic          readAck;
  logic          writeAck;
  logic          timeoutErr;

  modport slave (
    input  p0Address, p0WriteData,
    input  p0ReadReq, p0WriteReq,
    output p0ReadData, p0ReadAck, p0WriteAck,
    input  p1Address, p1WriteData,
    input  p1ReadReq, p1WriteReq,
    output p1ReadData, p1ReadAck, p1WriteAck,
    output ramAddress, ramOut,
    output readReq, writeReq,
    input  ramIn, readAck, writeAck,
    output timeoutErr
  );

  modport master (
    output p0Address, p0WriteData,
    output p0ReadReq, p0WriteReq,
    input  p0ReadData, p0ReadAck, p0WriteAck,
    output p1Address, p1WriteData,
    output p1ReadReq, p1WriteReq,
    input  p1ReadData, p1ReadAck, p1WriteAck,
    input  ramAddress, ramOut,
    input  readReq, writeReq,
    output ramIn, readAck, writeAck,
    input  timeoutErr
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one RAM port between the core (p0) and loader (p1).
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin ties instead of p0 priority.
module ram_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT = 0
) (
  input logic clk,
  input logic reset,
  ram_port_arbiter_if.slave bus
);
  typedef enum logic {IDLE, WAIT} state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [DW-1:0] BAD = DW'(32'hdeadbeef);

  state_t state, stateNext;

  logic [1:0]    rdPulse, wrPulse;
  logic [AW-1:0] reqAddr [2];
  logic [DW-1:0] reqData [2];

  logic [1:0]    slotFull, slotWrite;
  logic [AW-1:0] slotAddr [2];
  logic [DW-1:0] slotData [2];

  logic [DW-1:0] rdData [2];
  logic [1:0]    ackR, ackW;
  logic [AW-1:0] addrReg;
  logic [DW-1:0] dataReg;
  logic          curPort, curWrite;
  logic          pick, issue;
  logic          matchAck, expired;
  logic          done, timedOut, errReg;
  logic [CW-1:0] waitCnt;

  assign rdPulse = {bus.p1ReadReq, bus.p0ReadReq};
  assign wrPulse = {bus.p1WriteReq, bus.p0WriteReq};
  assign reqAddr[0] = bus.p0Address;
  assign reqAddr[1] = bus.p1Address;
  assign reqData[0] = bus.p0WriteData;
  assign reqData[1] = bus.p1WriteData;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic lastGrant;

  always_comb begin
    unique case (1'b1)
      (slotFull == 2'b11): pick = ~lastGrant;
      (slotFull == 2'b01): pick = 1'b0;
      default:             pick = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) lastGrant <= 1'b1;
    else if (issue) lastGrant <= pick;
  end
`else
  assign pick = ~slotFull[0];
`endif

  // Hold off one cycle while the requester ack is out, so
  // a just-acked port can re-request before the next grant.
  assign issue = (state == IDLE) && (|slotFull)
               && !(|ackR) && !(|ackW);

  assign matchAck = curWrite ? bus.writeAck : bus.readAck;
  assign expired  = (TIMEOUT > 0)
                 && (waitCnt == CW'(TIMEOUT - 1));

  always_comb begin
    stateNext = state;
    done      = 1'b0;
    timedOut  = 1'b0;
    unique case (state)
      IDLE: if (issue) stateNext = WAIT;
      WAIT: begin
        if (matchAck) begin
          done      = 1'b1;
          stateNext = IDLE;
        end else if (expired) begin
          done      = 1'b1;
          timedOut  = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      waitCnt <= '0;
    end else begin
      state <= stateNext;
      if (state == WAIT && !done) waitCnt <= waitCnt + 1'b1;
      else waitCnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slotFull  <= '0;
      slotWrite <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (done && curPort == p[0]) begin
          slotFull[p] <= 1'b0;
        end else if (!slotFull[p]
                     && (rdPulse[p] || wrPulse[p])) begin
          slotFull[p]  <= 1'b1;
          slotWrite[p] <= wrPulse[p];
          slotAddr[p]  <= reqAddr[p];
          slotData[p]  <= reqData[p];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      curPort  <= 1'b0;
      curWrite <= 1'b0;
      addrReg  <= '0;
      dataReg  <= '0;
    end else if (issue) begin
      curPort  <= pick;
      curWrite <= slotWrite[pick];
      addrReg  <= slotAddr[pick];
      dataReg  <= slotData[pick];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ackR      <= '0;
      ackW      <= '0;
      rdData[0] <= '0;
      rdData[1] <= '0;
      errReg    <= 1'b0;
    end else begin
      ackR <= '0;
      ackW <= '0;
      if (done) begin
        ackR[curPort] <= !curWrite;
        ackW[curPort] <= curWrite;
        if (!curWrite)
          rdData[curPort] <= timedOut ? BAD : bus.ramIn;
      end
      if (timedOut) errReg <= 1'b1;
    end
  end

  assign bus.ramAddress = issue ? slotAddr[pick] : addrReg;
  assign bus.ramOut     = issue ? slotData[pick] : dataReg;
  assign bus.readReq    = issue && !slotWrite[pick];
  assign bus.writeReq   = issue && slotWrite[pick];

  assign bus.p0ReadData = rdData[0];
  assign bus.p1ReadData = rdData[1];
  assign bus.p0ReadAck  = ackR[0];
  assign bus.p1ReadAck  = ackR[1];
  assign bus.p0WriteAck = ackW[0];
  assign bus.p1WriteAck = ackW[1];
  assign bus.timeoutErr = errReg;
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single RAM port between two requesters: port 0 is the CPU core (instruction/data fetch and store); port 1 is the program loader/debug DMA.
- Both sides use the core's pulse protocol: a 1-cycle readReq/writeReq with address and data, then a 1-cycle readAck/writeAck returned any later cycle.
- Requests are latched, arbitrated, and issued one at a time to the RAM; each ack and its read data are routed back to the requester that issued the access.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 0, cycles to wait for RAM ack before aborting; 0 = wait forever.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- p0Address  in  AW  port 0 request address.
- p0WriteData  in  DW  port 0 write data.
- p0ReadReq  in  1  port 0 read request pulse.
- p0WriteReq  in  1  port 0 write request pulse.
- p0ReadData  out  DW  port 0 read data, valid with p0ReadAck.
- p0ReadAck  out  1  port 0 read acknowledge pulse.
- p0WriteAck  out  1  port 0 write acknowledge pulse.
- p1Address, p1WriteData, p1ReadReq, p1WriteReq, p1ReadData, p1ReadAck, p1WriteAck: same as port 0, for port 1.
- ramAddress  out  AW  address to RAM.
- ramOut  out  DW  write data to RAM.
- readReq  out  1  RAM read request pulse.
- writeReq  out  1  RAM write request pulse.
- ramIn  in  DW  RAM read data.
- readAck  in  1  RAM read acknowledge.
- writeAck  in  1  RAM write acknowledge.
- timeoutErr  out  1  sticky flag, set on any timed-out access.

Behaviour:
- Reset (synchronous, one cycle sufficient): all outputs 0; pending slots empty; state IDLE; timeout counter 0; last-grant = port 1, so port 0 wins the first tie.
- Capture:
  - Each port has one pending slot holding address, data and kind (R/W).
  - A req pulse loads the slot if it is empty.
  - A pulse while the slot is pending or in service is ignored; each port may have at most one outstanding access.
  - readReq and writeReq together in one cycle: the write is captured and the read is dropped.
- State machine:
  - IDLE: if any slot is pending, choose a winner, drive ramAddress/ramOut, pulse readReq or writeReq for exactly 1 cycle, go to WAIT.
  - WAIT: on a RAM ack matching the issued kind:
    - latch ramIn into the winner's ReadData (reads only);
    - pulse the winner's ReadAck/WriteAck on the next cycle;
    - clear the slot and go to IDLE.
  - A non-matching ack in WAIT is ignored.
- Latency:
  - Request pulse in cycle N, slot empty, arbiter IDLE: RAM req in cycle N+1.
  - RAM ack in cycle M: requester ack in cycle M+1.
  - Minimum round trip for an idle RAM acking 1 cycle after req: 3 cycles.
- Back-to-back: IDLE is entered in cycle M+1, so the next access can issue in cycle M+2. A new request from the just-acked port, pulsed in M+1, is captured in M+1 and is eligible from M+2.
- Arbitration: fixed priority, port 0 over port 1 (see Optional Feature).
- Outputs:
  - ramAddress/ramOut hold their last issued values until the next issue.
  - pXReadData holds until the next read ack to that port.
  - Ack outputs are exactly 1-cycle pulses.
- TIMEOUT > 0:
  - A counter increments each WAIT cycle.
  - When it reaches TIMEOUT with no ack: return an ack to the winner (read data = 32'hdeadbeef), set timeoutErr, go to IDLE.
  - A late RAM ack arriving in IDLE is ignored.
- timeoutErr clears only on reset.
- Reset mid-operation: pending and in-flight accesses are discarded and no ack is issued. Requesters are reset in the same cycle.

Optional Feature:
- Macro RAM_ARB_ROUND_ROBIN_EN.
- Defined: round-robin; on a tie, the port not granted last wins. last-grant updates at each issue.
- Undefined: fixed priority, port 0 always wins; port 1 may starve.

Test Plan:
- Single read: p0ReadReq with p0Address=0x10, RAM acks 1 cycle later with ramIn=0x12345678 -> readReq in cycle N+1 with ramAddress=0x10; p0ReadAck in N+3 with p0ReadData=0x12345678; port 1 outputs stay 0.
- Simultaneous: p0 reads 0x20 and p1 writes 0xCAFE to 0x40 in the same cycle -> p0 is issued first. p1 write issues in the cycle after p0ReadAck, with ramOut=0xCAFE and ramAddress=0x40. With RAM_ARB_ROUND_ROBIN_EN, a second tie grants p1 first.
- Duplicate pulse: p1ReadReq twice, 1 cycle apart, while RAM is stalled -> exactly one RAM readReq and one p1ReadAck.
- Read+write same cycle: p0ReadReq and p0WriteReq with data 0x55 -> only writeReq is issued; p0WriteAck is returned and p0ReadAck is never returned.
- Timeout: TIMEOUT=4, RAM never acks a p0 read -> p0ReadAck after 4 WAIT cycles with data 0xdeadbeef and timeoutErr=1; a late readAck afterwards produces no ack.
- Reset in WAIT: reset asserted while a p1 write is outstanding -> no p1WriteAck, all outputs 0 the next cycle, and a following p0 read completes normally.
